// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file port-A read arbiter.
// No logic: constants and the FSM state type only.
// Imported by rf_read_arb and rf_arb_starve_cnt.
package rf_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    // IDLE: CPU owns port A unless a debug grant happens this cycle.
    // READ: the cycle after a grant, when the register file returns debug data.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

endpackage

// File: rtl/rf_arb_starve_cnt.sv
// Saturating debug-starvation counter with synchronous clear; o_hit flags count == CNT_MAX.
// Latency: count visible one cycle after the increment, o_hit is combinational from the count.
// Backpressure: none; i_clr wins over i_inc, and the count holds once saturated.
module rf_arb_starve_cnt
    import rf_arb_pkg::*;
#(
    parameter int CNT_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(CNT_MAX);

    logic [CNT_W-1:0] r_cnt;

    // Count denied cycles, stop at the limit, drop to zero on clear or reset.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == LP_MAX);

endmodule

// File: rtl/rf_read_arb.sv
// Port-A read arbiter: CPU owns port A, debug reads take idle slots (or a forced slot if RF_READ_ARB_STARVE_EN).
// Latency: grant/ack combinational in the request cycle, dbg_rvalid/dbg_rdata one cycle later; port B is a wire.
// Backpressure: dbg_req held until dbg_ack; a forced grant stalls the CPU for exactly that one cycle.
module rf_read_arb
    import rf_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_use_a,
    input  logic              cpu_re_word,
    input  logic [ADDR_W-1:0] cpu_raddr_a,
    input  logic [ADDR_W-1:0] cpu_raddr_b,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_word,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              rf_re_word,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a
);

    state_t            r_state;
    logic              r_word;
    logic [DATA_W-1:0] r_rdata;

    logic              w_idle;
    logic              w_grant;
    logic              w_starve_hit;
    logic              w_rvalid;
    logic [ADDR_W-1:0] w_dbg_addr;
    logic [DATA_W-1:0] w_rdata_fmt;

    assign w_idle = (r_state == ST_IDLE);

`ifdef RF_READ_ARB_STARVE_EN
    // Counter is held clear while READ so requests seen then start counting next cycle.
    rf_arb_starve_cnt #(
        .CNT_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (~dbg_req | w_grant | ~w_idle),
        .i_inc (dbg_req & w_idle),
        .o_hit (w_starve_hit)
    );

    // Only a grant taken while the CPU wanted port A costs the CPU a cycle.
    assign cpu_stall = w_grant & cpu_use_a;
`else
    // No forced grants: legal STARVE_MAX values (1..255) never match zero.
    assign w_starve_hit = (STARVE_MAX == 0);
    assign cpu_stall    = 1'b0;
`endif

    assign w_grant = ~rst & w_idle & dbg_req & (~cpu_use_a | w_starve_hit);
    assign dbg_ack = w_grant;

    // Word reads fetch an aligned register pair, so the low address bit is dropped.
    assign w_dbg_addr = {dbg_addr[ADDR_W-1:1], dbg_addr[0] & ~dbg_word};

    assign rf_raddr_a = w_grant ? w_dbg_addr : cpu_raddr_a;
    assign rf_re_word = w_grant ? dbg_word   : cpu_re_word;
    assign rf_raddr_b = cpu_raddr_b;

    // A reset landing in READ suppresses the pulse and the capture.
    assign w_rvalid    = ~rst & (r_state == ST_READ);
    assign w_rdata_fmt = r_word ? rf_rdata_a : {{(DATA_W-8){1'b0}}, rf_rdata_a[7:0]};
    assign dbg_rvalid  = w_rvalid;
    assign dbg_rdata   = w_rvalid ? w_rdata_fmt : r_rdata;

    // FSM: a grant opens a single READ cycle, which always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (w_grant) begin
            r_state <= ST_READ;
        end else begin
            r_state <= ST_IDLE;
        end
    end

    // Remember the granted read width for formatting the returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= 1'b0;
        end else if (w_grant) begin
            r_word <= dbg_word;
        end
    end

    // Keep the last delivered result on dbg_rdata between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rvalid) begin
            r_rdata <= w_rdata_fmt;
        end
    end

endmodule

// File: tb/tb_rf_read_arb.sv
// Directed bench for rf_read_arb with a registered register-file model and a read-data scoreboard.
// Latency: expects ack in the request cycle and read data one cycle later.
// Backpressure: exercises CPU-owned port A, back-to-back requests, starvation and reset in READ.
module tb_rf_read_arb;

    logic        clk;
    logic        rst;
    logic        cpu_use_a;
    logic        cpu_re_word;
    logic [4:0]  cpu_raddr_a;
    logic [4:0]  cpu_raddr_b;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_word;
    logic [4:0]  dbg_addr;
    logic        dbg_ack;
    logic        dbg_rvalid;
    logic [15:0] dbg_rdata;
    logic        rf_re_word;
    logic [4:0]  rf_raddr_a;
    logic [4:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;

    logic [15:0] mem [32];
    logic [15:0] exp_q [$];
    logic [15:0] last_exp;
    int          total;
    int          bad;

    rf_read_arb #(
        .STARVE_MAX (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_use_a   (cpu_use_a),
        .cpu_re_word (cpu_re_word),
        .cpu_raddr_a (cpu_raddr_a),
        .cpu_raddr_b (cpu_raddr_b),
        .cpu_stall   (cpu_stall),
        .dbg_req     (dbg_req),
        .dbg_word    (dbg_word),
        .dbg_addr    (dbg_addr),
        .dbg_ack     (dbg_ack),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .rf_re_word  (rf_re_word),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_rdata_a  (rf_rdata_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the register-file model returns mem[address presented at the edge].
    task automatic tick();
        logic [4:0] a;
        a = rf_raddr_a;
        @(posedge clk);
        #1;
        rf_rdata_a = mem[a];
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic sb_check(input string tag);
        check({tag, "_qnonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            last_exp = exp_q.pop_front();
            check(tag, dbg_rdata, last_exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        last_exp = '0;
        for (int i = 0; i < 32; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
        mem[7]  = 16'hAB5C;
        mem[28] = 16'h1234;
        mem[29] = 16'hBEEF;
        mem[12] = 16'hC0DE;
        mem[6]  = 16'h7E81;

        // Reset with both masters asking for port A.
        rst = 1'b1; cpu_use_a = 1'b1; cpu_re_word = 1'b1; cpu_raddr_a = 5'd3; cpu_raddr_b = 5'd9;
        dbg_req = 1'b1; dbg_word = 1'b0; dbg_addr = 5'd7; rf_rdata_a = '0;
        tick(); tick();
        settle();
        check("rst_ack", dbg_ack, 0);
        check("rst_stall", cpu_stall, 0);
        check("rst_rvalid", dbg_rvalid, 0);
        check("rst_rdata", dbg_rdata, 0);
        check("rst_raddr_a", rf_raddr_a, 5'd3);
        check("rst_re_word", rf_re_word, 1);
        check("rst_raddr_b", rf_raddr_b, 5'd9);
        tick();
        rst = 1'b0; dbg_req = 1'b0;
        tick();

        // Byte read in a free slot.
        cpu_use_a = 1'b0; cpu_re_word = 1'b1; dbg_req = 1'b1; dbg_addr = 5'd7; dbg_word = 1'b0;
        exp_q.push_back({8'h00, mem[7][7:0]});
        settle();
        check("byte_ack", dbg_ack, 1);
        check("byte_raddr", rf_raddr_a, 5'd7);
        check("byte_re_word", rf_re_word, 0);
        check("byte_stall", cpu_stall, 0);
        tick();
        dbg_req = 1'b0;
        settle();
        check("byte_rvalid", dbg_rvalid, 1);
        sb_check("byte_rdata");
        tick();
        settle();
        check("hold_rvalid", dbg_rvalid, 0);
        check("hold_rdata", dbg_rdata, last_exp);
        check("idle_raddr", rf_raddr_a, 5'd3);

        // Word read at an odd address goes to the aligned pair.
        dbg_req = 1'b1; dbg_addr = 5'd29; dbg_word = 1'b1; cpu_re_word = 1'b0;
        exp_q.push_back(mem[28]);
        settle();
        check("word_ack", dbg_ack, 1);
        check("word_raddr", rf_raddr_a, 5'd28);
        check("word_re_word", rf_re_word, 1);
        tick();
        dbg_req = 1'b0;
        settle();
        check("word_rvalid", dbg_rvalid, 1);
        sb_check("word_rdata");
        tick();

        // Request held across READ: READ blocks the grant, the next cycle grants again.
        dbg_req = 1'b1; dbg_addr = 5'd3; dbg_word = 1'b0;
        exp_q.push_back({8'h00, mem[3][7:0]});
        settle();
        check("b2b_ack0", dbg_ack, 1);
        tick();
        dbg_addr = 5'd12; dbg_word = 1'b1;
        exp_q.push_back(mem[12]);
        settle();
        check("b2b_read_ack", dbg_ack, 0);
        check("b2b_read_rvalid", dbg_rvalid, 1);
        sb_check("b2b_rdata0");
        tick();
        settle();
        check("b2b_ack1", dbg_ack, 1);
        check("b2b_raddr1", rf_raddr_a, 5'd12);
        tick();
        dbg_req = 1'b0;
        settle();
        sb_check("b2b_rdata1");
        tick();

        // Request dropped before any ack: nothing issued.
        cpu_use_a = 1'b1; cpu_raddr_a = 5'd17; dbg_req = 1'b1; dbg_addr = 5'd11; dbg_word = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("drop_ack", dbg_ack, 0);
            tick();
        end
        dbg_req = 1'b0;
        settle();
        check("drop_ack_low", dbg_ack, 0);
        tick();
        settle();
        check("drop_rvalid", dbg_rvalid, 0);

        // CPU holds port A every cycle while debug waits.
        dbg_req = 1'b1;
        exp_q.push_back({8'h00, mem[11][7:0]});
`ifdef RF_READ_ARB_STARVE_EN
        for (int k = 0; k <= 8; k++) begin
            settle();
            check("starve_ack", dbg_ack, 32'(k == 8));
            check("starve_stall", cpu_stall, 32'(k == 8));
            check("starve_raddr", rf_raddr_a, (k == 8) ? 32'd11 : 32'd17);
            tick();
        end
        dbg_req = 1'b0;
        settle();
        check("starve_rvalid", dbg_rvalid, 1);
        check("starve_stall_after", cpu_stall, 0);
        sb_check("starve_rdata");
        tick();
`else
        for (int k = 0; k < 12; k++) begin
            settle();
            check("nostarve_ack", dbg_ack, 0);
            check("nostarve_stall", cpu_stall, 0);
            check("nostarve_raddr", rf_raddr_a, 5'd17);
            tick();
        end
        cpu_use_a = 1'b0;
        settle();
        check("nostarve_ack_free", dbg_ack, 1);
        check("nostarve_stall_free", cpu_stall, 0);
        tick();
        dbg_req = 1'b0;
        settle();
        check("nostarve_rvalid", dbg_rvalid, 1);
        sb_check("nostarve_rdata");
        tick();
`endif

        // Reset arriving in the READ cycle discards the read.
        cpu_use_a = 1'b0; dbg_req = 1'b1; dbg_addr = 5'd4; dbg_word = 1'b1;
        settle();
        check("rstrd_ack", dbg_ack, 1);
        tick();
        dbg_req = 1'b0; rst = 1'b1;
        settle();
        check("rstrd_rvalid", dbg_rvalid, 0);
        tick();
        rst = 1'b0;
        settle();
        check("rstrd_rvalid_after", dbg_rvalid, 0);
        check("rstrd_rdata_cleared", dbg_rdata, 0);
        dbg_req = 1'b1; dbg_addr = 5'd7; dbg_word = 1'b1;
        exp_q.push_back(mem[6]);
        settle();
        check("post_rst_ack", dbg_ack, 1);
        check("post_rst_raddr", rf_raddr_a, 5'd6);
        tick();
        dbg_req = 1'b0;
        settle();
        check("post_rst_rvalid", dbg_rvalid, 1);
        sb_check("post_rst_rdata");
        tick();

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
